// File: rtl/wb_commit_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_stage_pkg
// Shared constants for the writeback/commit stage: exception code values,
// entry field widths and the packed commit-entry width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_commit_stage_pkg;

  localparam int ECODE_W    = 6;
  localparam int ESUBCODE_W = 9;

  // System-call exception code
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0b;

  // Packed entry = {pc, dest, result, gr_we, ex, ecode, esubcode}
  function automatic int wb_entry_w(input int xlen, input int aw);
    return xlen + aw + xlen + 1 + 1 + ECODE_W + ESUBCODE_W;
  endfunction

endpackage

// File: rtl/wb_commit_stage_if.sv
// -----------------------------------------------------------------------------
// wb_commit_stage_if
// MEM -> WB handshake bus carrying one completed instruction per transfer
// (transfer = in_valid & in_ready).
//   master : MEM side, drives the payload and in_valid, receives in_ready
//   slave  : commit stage, receives the payload, drives in_ready
// -----------------------------------------------------------------------------
interface wb_commit_stage_if
  import wb_commit_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [AW-1:0]         in_dest;
  logic [XLEN-1:0]       in_result;
  logic                  in_gr_we;
  logic                  in_ex;
  logic [ECODE_W-1:0]    in_ecode;
  logic [ESUBCODE_W-1:0] in_esubcode;

  modport master (
    output in_valid, in_pc, in_dest, in_result, in_gr_we, in_ex, in_ecode, in_esubcode,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_dest, in_result, in_gr_we, in_ex, in_ecode, in_esubcode,
    output in_ready
  );
endinterface

// File: rtl/wb_commit_fifo.sv
// -----------------------------------------------------------------------------
// wb_commit_fifo
// DEPTH-entry synchronous circular FIFO with a combinational head read port.
// flush empties the buffer and wins over a same-cycle push/pop.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  write an entry at the tail
//   pop          drop the head entry
//   flush        discard everything, pointers back to 0
//   rdata        head entry
//   count        entries held
// -----------------------------------------------------------------------------
module wb_commit_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_push_s = push & ~flush;
  assign do_pop_s  = pop & ~flush;

  // Entry storage; cleared on reset so the head port never shows stale data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push+pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/wb_commit_stage.sv
// -----------------------------------------------------------------------------
// wb_commit_stage
// Writeback/commit stage: buffers up to DEPTH completed instructions from MEM,
// retires one per cycle in order to the GPR file, raises precise exceptions at
// retire and forwards the oldest pending result to ID.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_bus (slave)             MEM handshake + instruction payload
//   stall                      hold retirement this cycle
//   rf_we/rf_waddr/rf_wdata    GPR write port
//   fwd_dest/fwd_data          head-entry bypass to ID (dest 0 = none)
//   wb_ex/wb_ecode/wb_esubcode/wb_pc  exception retire pulse and its cause
//   occupancy                  entries held
// Optional (WB_DEBUG_TRACE_EN): debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
//   debug_wb_rf_wdata retire trace.
// -----------------------------------------------------------------------------
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int AW    = 5,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_commit_stage_if.slave      in_bus,
  input  logic                  stall,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [AW-1:0]         fwd_dest,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  wb_ex,
  output logic [ECODE_W-1:0]    wb_ecode,
  output logic [ESUBCODE_W-1:0] wb_esubcode,
  output logic [XLEN-1:0]       wb_pc,
  output logic [CW-1:0]         occupancy
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [XLEN-1:0]       debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [AW-1:0]         debug_wb_rf_wnum,
  output logic [XLEN-1:0]       debug_wb_rf_wdata
`endif
);

  localparam int EW = wb_entry_w(XLEN, AW);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]            state_r;
  logic [EW-1:0]         push_entry_s;
  logic [EW-1:0]         head_s;
  logic [CW-1:0]         count_s;
  logic                  run_s;
  logic                  not_empty_s;
  logic                  retire_s;
  logic                  push_s;

  logic [XLEN-1:0]       h_pc;
  logic [AW-1:0]         h_dest;
  logic [XLEN-1:0]       h_result;
  logic                  h_gr_we;
  logic                  h_ex;
  logic [ECODE_W-1:0]    h_ecode;
  logic [ESUBCODE_W-1:0] h_esubcode;

  assign push_entry_s = {in_bus.in_pc, in_bus.in_dest, in_bus.in_result, in_bus.in_gr_we,
                         in_bus.in_ex, in_bus.in_ecode, in_bus.in_esubcode};
  assign {h_pc, h_dest, h_result, h_gr_we, h_ex, h_ecode, h_esubcode} = head_s;

  assign run_s       = (state_r == ST_RUN);
  assign not_empty_s = (count_s != '0);
  // Reset is gated in so nothing leaves the stage during the reset cycle
  assign retire_s    = not_empty_s & ~stall & run_s & ~reset;

  // A full buffer still accepts when the head retires this cycle
  assign in_bus.in_ready = run_s & ((count_s < CW'(DEPTH)) | retire_s);
  assign push_s          = in_bus.in_valid & in_bus.in_ready;

  wb_commit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (retire_s),
    .flush (wb_ex),
    .wdata (push_entry_s),
    .rdata (head_s),
    .count (count_s)
  );

  // RUN/FLUSH sequencing: a retired exception costs exactly one bubble cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:   state_r <= wb_ex ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_r <= ST_RUN;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

  // An excepting entry never writes the GPR file
  assign rf_we    = retire_s & h_gr_we & ~h_ex;
  assign rf_waddr = rf_we ? h_dest : '0;
  assign rf_wdata = rf_we ? h_result : '0;

  assign wb_ex       = retire_s & h_ex;
  assign wb_ecode    = wb_ex ? h_ecode : '0;
  assign wb_esubcode = wb_ex ? h_esubcode : '0;
  assign wb_pc       = wb_ex ? h_pc : '0;

  assign fwd_dest  = (not_empty_s & h_gr_we & ~h_ex & run_s) ? h_dest : '0;
  assign fwd_data  = h_result;
  assign occupancy = count_s;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = retire_s ? h_pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = retire_s ? h_dest : '0;
  assign debug_wb_rf_wdata = retire_s ? h_result : '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [1:0]  occupancy;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int errors = 0;
  int checks = 0;

  wb_commit_stage_if #(.XLEN(XLEN), .AW(AW)) bus ();

  wb_commit_stage #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_bus      (bus),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_dest    (fwd_dest),
    .fwd_data    (fwd_data),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .occupancy   (occupancy)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] d,
                        input logic [31:0] r, input logic we, input logic ex,
                        input logic [5:0] ec, input logic [8:0] es);
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_dest     = d;
    bus.in_result   = r;
    bus.in_gr_we    = we;
    bus.in_ex       = ex;
    bus.in_ecode    = ec;
    bus.in_esubcode = es;
  endtask

  task automatic idle_in();
    set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (in_ready_v() !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_v()); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if ({rf_we, wb_ex} !== 2'b00) begin errors++; $display("FAIL reset_we_ex got=%b exp=00", {rf_we, wb_ex}); end
    checks++; if (fwd_dest !== 5'd0 || rf_waddr !== 5'd0 || wb_pc !== 32'h0) begin
      errors++; $display("FAIL reset_outs fwd=%0d waddr=%0d wbpc=%h exp=0", fwd_dest, rf_waddr, wb_pc); end
  endtask

  function automatic logic in_ready_v();
    return bus.in_ready;
  endfunction

  task automatic test_basic();
    set_in(1'b1, 32'h1c000000, 5'd5, 32'h1234, 1'b1, 1'b0, 6'h0, 9'h0);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL basic_empty_we got=%0b exp=0", rf_we); end
    tick();
    idle_in();
    #1;
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ1 got=%0d exp=1", occupancy); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL basic_write we=%0b waddr=%0d wdata=%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fwd_dest !== 5'd5) begin errors++; $display("FAIL basic_fwd got=%0d exp=5", fwd_dest); end
`ifdef WB_DEBUG_TRACE_EN
    checks++; if (debug_wb_rf_we !== 4'hf || debug_wb_pc !== 32'h1c000000 || debug_wb_rf_wnum !== 5'd5) begin
      errors++; $display("FAIL dbg_trace we=%h pc=%h wnum=%0d exp=f/1c000000/5", debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wnum); end
`endif
    tick();
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL basic_drained occ=%0d we=%0b exp=0/0", occupancy, rf_we); end
  endtask

  task automatic test_stall_fill();
    stall = 1'b1;
    set_in(1'b1, 32'h100, 5'd1, 32'h11, 1'b1, 1'b0, 6'h0, 9'h0);
    #1;
    checks++; if (in_ready_v() !== 1'b1) begin errors++; $display("FAIL stall_rdy0 got=%0b exp=1", in_ready_v()); end
    tick();
    set_in(1'b1, 32'h104, 5'd2, 32'h22, 1'b1, 1'b0, 6'h0, 9'h0);
    #1;
    checks++; if (in_ready_v() !== 1'b1) begin errors++; $display("FAIL stall_rdy1 got=%0b exp=1", in_ready_v()); end
    tick();
    set_in(1'b1, 32'h108, 5'd3, 32'h33, 1'b1, 1'b0, 6'h0, 9'h0);
    #1;
    checks++; if (in_ready_v() !== 1'b0 || occupancy !== 2'd2 || rf_we !== 1'b0) begin
      errors++; $display("FAIL stall_full rdy=%0b occ=%0d we=%0b exp=0/2/0", in_ready_v(), occupancy, rf_we); end
    tick();
    idle_in();
    stall = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin
      errors++; $display("FAIL stall_ret0 we=%0b waddr=%0d wdata=%h exp=1/1/11", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22 || occupancy !== 2'd1) begin
      errors++; $display("FAIL stall_ret1 we=%0b waddr=%0d wdata=%h occ=%0d exp=1/2/22/1", rf_we, rf_waddr, rf_wdata, occupancy); end
    tick();
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL stall_drained occ=%0d we=%0b exp=0/0", occupancy, rf_we); end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1;
    for (int k = 10; k < 12; k++) begin
      set_in(1'b1, 32'h200 + 32'(k), 5'(k), 32'h100 + 32'(k), 1'b1, 1'b0, 6'h0, 9'h0);
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h200 + 32'(12 + i), 5'(12 + i), 32'h100 + 32'(12 + i), 1'b1, 1'b0, 6'h0, 9'h0);
      #1;
      checks++; if (in_ready_v() !== 1'b1 || occupancy !== 2'd2) begin
        errors++; $display("FAIL b2b_full[%0d] rdy=%0b occ=%0d exp=1/2", i, in_ready_v(), occupancy); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== 32'h100 + 32'(10 + i)) begin
        errors++; $display("FAIL b2b_ret[%0d] we=%0b waddr=%0d wdata=%h exp=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 10 + i, 32'h100 + 32'(10 + i)); end
      tick();
    end
    idle_in();
    #1;
    checks++; if (rf_waddr !== 5'd13) begin errors++; $display("FAIL b2b_tail0 got=%0d exp=13", rf_waddr); end
    tick();
    checks++; if (rf_waddr !== 5'd14) begin errors++; $display("FAIL b2b_tail1 got=%0d exp=14", rf_waddr); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_drained got=%0d exp=0", occupancy); end
  endtask

  task automatic test_exception();
    stall = 1'b1;
    set_in(1'b1, 32'h1c000030, 5'd3, 32'h3333, 1'b1, 1'b0, 6'h0, 9'h0);
    tick();
    set_in(1'b1, 32'h1c000040, 5'd4, 32'h4444, 1'b1, 1'b1, ECODE_SYS, 9'h001);
    tick();
    idle_in();
    stall = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || wb_ex !== 1'b0) begin
      errors++; $display("FAIL ex_pending we=%0b waddr=%0d ex=%0b exp=1/3/0", rf_we, rf_waddr, wb_ex); end
    tick();
    // an offered entry in the exception cycle must be discarded
    set_in(1'b1, 32'h1c000050, 5'd8, 32'h8888, 1'b1, 1'b0, 6'h0, 9'h0);
    #1;
    checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h0b || wb_esubcode !== 9'h001 || wb_pc !== 32'h1c000040) begin
      errors++; $display("FAIL ex_pulse ex=%0b ecode=%h esub=%h pc=%h exp=1/0b/001/1c000040", wb_ex, wb_ecode, wb_esubcode, wb_pc); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ex_no_write got=%0b exp=0", rf_we); end
    tick();
    checks++; if (wb_ex !== 1'b0 || in_ready_v() !== 1'b0 || occupancy !== 2'd0 || wb_pc !== 32'h0) begin
      errors++; $display("FAIL ex_flush ex=%0b rdy=%0b occ=%0d pc=%h exp=0/0/0/0", wb_ex, in_ready_v(), occupancy, wb_pc); end
    idle_in();
    tick();
    checks++; if (in_ready_v() !== 1'b1 || occupancy !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL ex_resume rdy=%0b occ=%0d we=%0b exp=1/0/0", in_ready_v(), occupancy, rf_we); end
  endtask

  task automatic test_forward();
    stall = 1'b1;
    set_in(1'b1, 32'h300, 5'd7, 32'hcafe, 1'b1, 1'b0, 6'h0, 9'h0);
    tick();
    idle_in();
    #1;
    checks++; if (fwd_dest !== 5'd7 || fwd_data !== 32'hcafe || rf_we !== 1'b0) begin
      errors++; $display("FAIL fwd_head dest=%0d data=%h we=%0b exp=7/cafe/0", fwd_dest, fwd_data, rf_we); end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    set_in(1'b1, 32'h304, 5'd9, 32'hbeef, 1'b1, 1'b1, ECODE_SYS, 9'h0);
    tick();
    idle_in();
    #1;
    checks++; if (fwd_dest !== 5'd0 || wb_ex !== 1'b0) begin
      errors++; $display("FAIL fwd_ex_head dest=%0d ex=%0b exp=0/0", fwd_dest, wb_ex); end
    stall = 1'b0;
    #1;
    checks++; if (wb_ex !== 1'b1 || wb_pc !== 32'h304) begin
      errors++; $display("FAIL fwd_ex_release ex=%0b pc=%h exp=1/304", wb_ex, wb_pc); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    set_in(1'b1, 32'h400, 5'd4, 32'h44, 1'b1, 1'b0, 6'h0, 9'h0);
    tick();
    set_in(1'b1, 32'h404, 5'd6, 32'h66, 1'b1, 1'b0, 6'h0, 9'h0);
    tick();
    idle_in();
    stall = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || wb_ex !== 1'b0) begin
      errors++; $display("FAIL rst_mid_cycle we=%0b ex=%0b exp=0/0", rf_we, wb_ex); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0 || wb_ex !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after occ=%0d we=%0b ex=%0b exp=0/0/0", occupancy, rf_we, wb_ex); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_fill();
    test_back_to_back();
    test_exception();
    test_forward();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
